// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO flag controller: the {wr,rd} operation
// encoding and threshold legality checks used at elaboration.
package fifo_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    BOTH  = 2'b11
  } fifo_op_e;

  function automatic bit af_thr_legal(int thr, int depth);
    return (thr >= 1) && (thr <= depth - 1);
  endfunction

  function automatic bit ae_thr_legal(int thr, int depth);
    return (thr >= 0) && (thr <= depth - 2);
  endfunction

endpackage

// File: rtl/fifo_flag_ctrl_if.sv
// Request/flag bundle between a FIFO user (master) and the flag controller (slave).
interface fifo_flag_ctrl_if #(
  parameter int AddrBits = 4
);
  // wr_i/rd_i are requests with no ready; wr_en_o/rd_en_o report same-cycle
  // acceptance, and a request that is not accepted is dropped, not held.
  logic                wr_i;
  logic                rd_i;
  logic                flush_i;
  logic                clr_err_i;
  logic [AddrBits-1:0] w_addr_o;
  logic [AddrBits-1:0] r_addr_o;
  logic                wr_en_o;
  logic                rd_en_o;
  logic [AddrBits:0]   count_o;
  logic                empty_o;
  logic                full_o;
  logic                almost_empty_o;
  logic                almost_full_o;
  logic                overflow_o;
  logic                underflow_o;

  modport master (
    output wr_i, rd_i, flush_i, clr_err_i,
    input  w_addr_o, r_addr_o, wr_en_o, rd_en_o, count_o,
           empty_o, full_o, almost_empty_o, almost_full_o,
           overflow_o, underflow_o
  );

  modport slave (
    input  wr_i, rd_i, flush_i, clr_err_i,
    output w_addr_o, r_addr_o, wr_en_o, rd_en_o, count_o,
           empty_o, full_o, almost_empty_o, almost_full_o,
           overflow_o, underflow_o
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping register-file pointer with synchronous clear and increment.
module fifo_ptr #(
  parameter int Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] ptr
);

  // Natural binary overflow gives the DEPTH-1 -> 0 wrap for a power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + Width'(1);
    end
  end

endmodule

// File: rtl/fifo_flag_ctrl.sv
// FIFO pointer/occupancy/flag controller for an external register file.
// Define FIFO_FLAG_CTRL_ERR_EN to build the sticky overflow/underflow flags.
import fifo_pkg::*;

module fifo_flag_ctrl #(
  parameter int AddrBits       = 4,
  parameter int AlmostFullThr  = 14,
  parameter int AlmostEmptyThr = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  fifo_flag_ctrl_if.slave bus
);

  localparam int                Depth     = 2 ** AddrBits;
  localparam logic [AddrBits:0] FullCount = (AddrBits + 1)'(Depth);
  localparam logic [AddrBits:0] AfThr     = (AddrBits + 1)'(AlmostFullThr);
  localparam logic [AddrBits:0] AeThr     = (AddrBits + 1)'(AlmostEmptyThr);

  if (!af_thr_legal(AlmostFullThr, Depth)) begin : g_bad_af_thr
    $error("fifo_flag_ctrl: AlmostFullThr out of range 1..DEPTH-1");
  end
  if (!ae_thr_legal(AlmostEmptyThr, Depth)) begin : g_bad_ae_thr
    $error("fifo_flag_ctrl: AlmostEmptyThr out of range 0..DEPTH-2");
  end

  logic [AddrBits:0]   count;
  logic [AddrBits-1:0] w_addr;
  logic [AddrBits-1:0] r_addr;
  logic                rd_en;
  logic                wr_en;
  fifo_op_e            op;

  // A write into a full FIFO is allowed when a read frees a slot in the same cycle.
  always_comb begin
    rd_en = bus.rd_i && !bus.flush_i && (count != '0);
    wr_en = bus.wr_i && !bus.flush_i && ((count != FullCount) || rd_en);
    op    = fifo_op_e'({wr_en, rd_en});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      count <= '0;
    end else begin
      case (op)
        WRITE:   count <= count + (AddrBits + 1)'(1);
        READ:    count <= count - (AddrBits + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  fifo_ptr #(.Width(AddrBits)) u_wptr (
    .clk (clk_i),
    .rst (rst_i),
    .clr (bus.flush_i),
    .inc (wr_en),
    .ptr (w_addr)
  );

  fifo_ptr #(.Width(AddrBits)) u_rptr (
    .clk (clk_i),
    .rst (rst_i),
    .clr (bus.flush_i),
    .inc (rd_en),
    .ptr (r_addr)
  );

  assign bus.w_addr_o       = w_addr;
  assign bus.r_addr_o       = r_addr;
  assign bus.wr_en_o        = wr_en;
  assign bus.rd_en_o        = rd_en;
  assign bus.count_o        = count;
  assign bus.empty_o        = (count == '0);
  assign bus.full_o         = (count == FullCount);
  assign bus.almost_empty_o = (count <= AeThr);
  assign bus.almost_full_o  = (count >= AfThr);

`ifdef FIFO_FLAG_CTRL_ERR_EN
  logic overflow;
  logic underflow;
  logic wr_refused;
  logic rd_refused;

  // Requests masked by flush are ignored rather than refused.
  assign wr_refused = bus.wr_i && !bus.flush_i && !wr_en;
  assign rd_refused = bus.rd_i && !bus.flush_i && !rd_en;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  && !bus.clr_err_i) || wr_refused;
      underflow <= (underflow && !bus.clr_err_i) || rd_refused;
    end
  end

  assign bus.overflow_o  = overflow;
  assign bus.underflow_o = underflow;
`else
  logic unused_clr_err;
  assign unused_clr_err  = bus.clr_err_i;
  assign bus.overflow_o  = 1'b0;
  assign bus.underflow_o = 1'b0;
`endif

endmodule

// File: doc/fifo_flag_ctrl.md
FIFO_FLAG_CTRL -- requirements
Module: fifo_flag_ctrl

Interface
REQ-001 Parameter: AddrBits, default 4, address width; depth DEPTH = 2**AddrBits entries.
REQ-002 Parameter: AlmostFullThr, default 14, occupancy at or above which almost_full_o asserts; legal range 1..DEPTH-1.
REQ-003 Parameter: AlmostEmptyThr, default 2, occupancy at or below which almost_empty_o asserts; legal range 0..DEPTH-2.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 wr_i  input  1  write request.
REQ-007 rd_i  input  1  read request.
REQ-008 flush_i  input  1  synchronous flush to empty.
REQ-009 clr_err_i  input  1  clears sticky error flags.
REQ-010 w_addr_o  output  AddrBits  register-file write address (write pointer).
REQ-011 r_addr_o  output  AddrBits  register-file read address (read pointer).
REQ-012 wr_en_o  output  1  write accepted this cycle; gates the register-file write.
REQ-013 rd_en_o  output  1  read accepted this cycle.
REQ-014 count_o  output  AddrBits+1  current occupancy, 0..DEPTH.
REQ-015 empty_o / full_o  output  1 each  count_o == 0 / count_o == DEPTH.
REQ-016 almost_empty_o / almost_full_o  output  1 each  threshold flags.
REQ-017 overflow_o / underflow_o  output  1 each  sticky error flags.

Function
REQ-018 Pointers, count and error flags are registers; all other outputs decode combinationally from registers and current-cycle requests only.
REQ-019 Read accepted (rd_en_o=1) iff rd_i=1, flush_i=0 and count_o>0.
REQ-020 Write accepted (wr_en_o=1) iff wr_i=1, flush_i=0 and (count_o<DEPTH, or a read is accepted the same cycle).
REQ-021 Accepted write: w_addr_o increments by 1 next cycle, wrapping DEPTH-1 -> 0; accepted read: same for r_addr_o.
REQ-022 count_o next = count_o + wr_en_o - rd_en_o; simultaneous accepted read and write leave count_o unchanged.
REQ-023 Simultaneous rd_i and wr_i when empty: only the write is accepted; count_o becomes 1, r_addr_o unchanged.
REQ-024 Simultaneous rd_i and wr_i when full: both accepted; full_o remains 1; both pointers advance.
REQ-025 Read data is valid at r_addr_o in the cycle rd_en_o=1; written data appears at w_addr_o in the cycle wr_en_o=1; a written entry is readable from the next cycle (1-cycle write-to-read latency).
REQ-026 almost_full_o = (count_o >= AlmostFullThr); almost_empty_o = (count_o <= AlmostEmptyThr).
REQ-027 flush_i=1: both pointers and count_o become 0 next cycle; rd_i/wr_i ignored that cycle; error flags unaffected.
REQ-028 Refused request (rd_i with count 0, wr_i with count DEPTH and no accepted read) changes no pointer or count.

Reset
REQ-029 rst_i=1 at a rising edge: pointers 0, count_o 0, overflow_o 0, underflow_o 0; hence empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0.
REQ-030 Reset has priority over flush_i, clr_err_i, rd_i and wr_i, including mid-operation; stored contents are discarded.

Configuration
REQ-031 Macro FIFO_FLAG_CTRL_ERR_EN defined: overflow_o sets on a refused write, underflow_o sets on a refused read; both hold until clr_err_i=1 or reset; a set and clr_err_i in the same cycle leave the flag set.
REQ-032 Macro undefined: overflow_o and underflow_o are tied 0, clr_err_i is ignored, no error-flag registers exist; ports remain.

Structure
REQ-033 Shared package fifo_pkg holds the {wr,rd} operation encoding (NONE=00, READ=01, WRITE=10, BOTH=11) as a typedef enum and threshold-legality check functions.
REQ-034 One sub-module, fifo_ptr, implements a parametrised wrapping pointer with increment and clear; it is instantiated twice.
REQ-035 Elaboration fails if AlmostFullThr or AlmostEmptyThr lies outside its legal range.

Verification (defaults, DEPTH=16)
REQ-036 Reset, then 16 writes -> full_o=1 on the cycle after the 16th; count_o=16; almost_full_o from count 14; w_addr_o wraps to 0.
REQ-037 Full, then 17th write -> wr_en_o=0, pointers and count unchanged; overflow_o=1 with macro, 0 without.
REQ-038 Empty, rd_i=1 and wr_i=1 together -> wr_en_o=1, rd_en_o=0, count_o=1, r_addr_o=0.
REQ-039 Full, rd_i=1 and wr_i=1 for 20 cycles -> count_o stays 16; both pointers advance 20 modulo 16 to 4.
REQ-040 count_o=9, flush_i=1 with wr_i=1 -> next cycle count_o=0, pointers 0, empty_o=1, wr_en_o=0 during flush.
REQ-041 rst_i asserted with count_o=5 and underflow_o=1 -> next cycle all outputs at reset values per REQ-029.
